// File: rtl/pcie_wr_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcie_wr_seq_pkg
// Purpose  : Shared constants, state encoding and address helper for the
//            PCIe write-request sequencer (pcie_wr_seq).
// Contents : REQ_BYTES, BEATS_PER_REQ, REQS_PER_PAGE, PAGE_SHIFT, derived
//            slot widths, state_t enum, page_base() helper.
// Revision : 1.0 - initial release
// ============================================================================
package pcie_wr_seq_pkg;

  // One request is 128 bytes = 32 DW = 16 beats of 64 bits.
  localparam int REQ_BYTES     = 128;
  localparam int BEATS_PER_REQ = 16;
  localparam int REQS_PER_PAGE = 32;
  localparam int PAGE_SHIFT    = 12;

  // Byte offset of a request inside its page lives in addr[PAGE_SHIFT-1:REQ_SHIFT].
  localparam int REQ_SHIFT = $clog2(REQ_BYTES);
  localparam int SLOT_W    = PAGE_SHIFT - REQ_SHIFT;
  localparam int BEAT_W    = $clog2(BEATS_PER_REQ);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    WAIT = 3'd2,
    XFER = 3'd3,
    HOLD = 3'd4
  } state_t;

  // Page-aligned byte address from the page frame number (pa_data[63:12]).
  function automatic logic [63:0] page_base(input logic [63-PAGE_SHIFT:0] pfn);
    return {pfn, {PAGE_SHIFT{1'b0}}};
  endfunction

endpackage : pcie_wr_seq_pkg
`default_nettype wire

// File: rtl/pcie_wr_seq.sv
`default_nettype none
// ============================================================================
// Module   : pcie_wr_seq
// Purpose  : Write-request sequencer feeding the PCIe TX TLP formatter.
//            Pops 4 KiB page addresses, then issues 32 back-to-back 128-byte
//            memory-write requests per page, each drained as 16 x 64-bit
//            beats from an FWFT data FIFO.
// Revision : 1.0 - initial release
//
// Ports
//   clock       in   system clock
//   reset       in   synchronous, active-high
//   enable      in   run; low blocks the start of any new request
//   pa_valid    in   page address available
//   pa_data     in   host page address (bits [11:0] ignored)
//   pa_ready    out  page address accepted this cycle (combinational, LOAD)
//   fifo_data   in   FWFT FIFO head word
//   fifo_count  in   FIFO occupancy in 64-bit words
//   fifo_rd_en  out  pop FIFO head (combinational from wr_ready in XFER)
//   wr_valid    out  request pending to the formatter (registered)
//   wr_addr     out  128-byte aligned request byte address
//   wr_data     out  beat data, pass-through of fifo_data
//   wr_ready    in   formatter consumed one beat this cycle
//   page_done   out  one-cycle pulse in the HOLD cycle of a page's 32nd request
//   req_count   out  completed requests since reset
//
// Build option
//   PCIE_WR_SEQ_REQ_COUNT_EN : when defined, req_count is a free-running
//                              32-bit count of HOLD cycles; otherwise it is
//                              tied to zero.
// ============================================================================
module pcie_wr_seq
  import pcie_wr_seq_pkg::*;
#(
  parameter int COUNT_W = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               pa_valid,
  input  logic [63:0]        pa_data,
  output logic               pa_ready,
  input  logic [63:0]        fifo_data,
  input  logic [COUNT_W-1:0] fifo_count,
  output logic               fifo_rd_en,
  output logic               wr_valid,
  output logic [63:0]        wr_addr,
  output logic [63:0]        wr_data,
  input  logic               wr_ready,
  output logic               page_done,
  output logic [31:0]        req_count
);

  localparam logic [COUNT_W-1:0] c_min_count = COUNT_W'(BEATS_PER_REQ);
  localparam logic [BEAT_W-1:0]  c_last_beat = BEAT_W'(BEATS_PER_REQ - 1);
  localparam logic [SLOT_W-1:0]  c_last_req  = SLOT_W'(REQS_PER_PAGE - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [BEAT_W-1:0]   r_beat_cnt;
  logic [SLOT_W-1:0]   r_req_idx;
  logic [63:0]         r_wr_addr;
  logic                r_wr_valid;
  logic                r_page_done;
  logic                w_last_beat;
  logic [SLOT_W-1:0]   w_next_slot;
  logic                w_unused_pa_low;

  // Low page-address bits are architecturally ignored.
  assign w_unused_pa_low = ^pa_data[PAGE_SHIFT-1:0];

  assign w_last_beat = (r_state == XFER) && wr_ready && (r_beat_cnt == c_last_beat);

  // Only the in-page slot field is incremented, so the page bits can never
  // carry and a request never crosses a 4 KiB boundary.
  assign w_next_slot = r_wr_addr[PAGE_SHIFT-1:REQ_SHIFT] + SLOT_W'(1);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (enable) w_next_state = LOAD;
      end
      LOAD: begin
        if (pa_valid) w_next_state = WAIT;
      end
      WAIT: begin
        // A whole request must already be in the FIFO so XFER never stalls
        // on data.
        if (enable && (fifo_count >= c_min_count)) w_next_state = XFER;
      end
      XFER: begin
        // enable is deliberately not looked at: a started request always
        // completes all of its beats.
        if (w_last_beat) w_next_state = HOLD;
      end
      HOLD: begin
        if (r_req_idx == c_last_req) begin
          w_next_state = enable ? LOAD : IDLE;
        end else begin
          w_next_state = WAIT;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State, address and request bookkeeping
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_beat_cnt  <= '0;
      r_req_idx   <= '0;
      r_wr_addr   <= '0;
      r_wr_valid  <= 1'b0;
      r_page_done <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_wr_valid  <= (w_next_state == XFER);
      // Registered so the pulse lines up exactly with the HOLD cycle.
      r_page_done <= w_last_beat && (r_req_idx == c_last_req);

      // Beat counter wraps to zero on the last beat, ready for the next request.
      if ((r_state == XFER) && wr_ready) begin
        r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
      end

      if ((r_state == LOAD) && pa_valid) begin
        r_wr_addr <= page_base(pa_data[63:PAGE_SHIFT]);
        r_req_idx <= '0;
      end

      // The formatter samples wr_addr after the last beat, so the address
      // moves only when HOLD is left.
      if (r_state == HOLD) begin
        r_wr_addr <= {r_wr_addr[63:PAGE_SHIFT], w_next_slot, {REQ_SHIFT{1'b0}}};
        r_req_idx <= r_req_idx + SLOT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional completed-request counter
  // --------------------------------------------------------------------------
`ifdef PCIE_WR_SEQ_REQ_COUNT_EN
  logic [31:0] r_req_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_req_count <= '0;
    end else if (r_state == HOLD) begin
      r_req_count <= r_req_count + 32'd1;
    end
  end

  assign req_count = r_req_count;
`else
  assign req_count = 32'd0;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign pa_ready   = (r_state == LOAD);
  // Zero-latency FWFT pop: the head word is consumed in the same cycle the
  // formatter takes the beat.
  assign fifo_rd_en = (r_state == XFER) && wr_ready;
  assign wr_valid   = r_wr_valid;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = fifo_data;
  assign page_done  = r_page_done;

endmodule : pcie_wr_seq
`default_nettype wire

// File: tb/tb_pcie_wr_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcie_wr_seq
// Purpose  : Self-checking bench for pcie_wr_seq. An FWFT FIFO model and a
//            randomly-throttled formatter drive the DUT; expected addresses
//            and beat data are queued at stimulus time and a negedge monitor
//            pops and compares them as beats are consumed.
// Revision : 1.0 - initial release
// Build option: PCIE_WR_SEQ_REQ_COUNT_EN selects the expected req_count.
// ============================================================================
module tb_pcie_wr_seq;
  import pcie_wr_seq_pkg::*;

  localparam int COUNT_W = 10;

  logic               clock;
  logic               reset;
  logic               enable;
  logic               pa_valid;
  logic [63:0]        pa_data;
  logic               pa_ready;
  logic [63:0]        fifo_data;
  logic [COUNT_W-1:0] fifo_count;
  logic               fifo_rd_en;
  logic               wr_valid;
  logic [63:0]        wr_addr;
  logic [63:0]        wr_data;
  logic               wr_ready;
  logic               page_done;
  logic [31:0]        req_count;

  pcie_wr_seq #(.COUNT_W(COUNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .pa_valid   (pa_valid),
    .pa_data    (pa_data),
    .pa_ready   (pa_ready),
    .fifo_data  (fifo_data),
    .fifo_count (fifo_count),
    .fifo_rd_en (fifo_rd_en),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .page_done  (page_done),
    .req_count  (req_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_data[$];
  logic [63:0] exp_addr[$];
  int word_seq = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- FWFT FIFO model ----------------
  logic [63:0] fmem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;

  always_comb begin
    if (wr_ptr - rd_ptr <= 0)         fifo_count = '0;
    else if (wr_ptr - rd_ptr > 1023)  fifo_count = 10'd1023;
    else                              fifo_count = 10'(wr_ptr - rd_ptr);
  end
  assign fifo_data = fmem[rd_ptr[11:0]];

  always @(posedge clock) begin
    if (reset)           rd_ptr <= 0;
    else if (fifo_rd_en) rd_ptr <= rd_ptr + 1;
  end

  task automatic push_words(input int n);
    logic [63:0] w;
    for (int i = 0; i < n; i++) begin
      w = {32'hCAFE_0000 + 32'(word_seq), ~32'(word_seq * 7)};
      fmem[wr_ptr[11:0]] = w;
      exp_data.push_back(w);
      wr_ptr++;
      word_seq++;
    end
  endtask

  task automatic push_addrs(input logic [63:0] base, input int first, input int last);
    for (int k = first; k <= last; k++) exp_addr.push_back(base + 64'(k * 128));
  endtask

  // ---------------- formatter (ready throttling) ----------------
  initial begin
    wr_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      wr_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor ----------------
  int beat_cnt = 0;
  int req_done = 0;
  int in_page  = 0;
  int pd_count = 0;
  int pa_acc   = 0;
  bit hold_chk = 0;
  logic [63:0] cur_addr = '0;

  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        beat_cnt = 0;
        req_done = 0;
        in_page  = 0;
        hold_chk = 0;
      end else begin
        if (page_done) pd_count++;
        if (hold_chk) begin
          // Cycle after the last beat: formatter samples the address here.
          check("hold_addr", wr_addr, cur_addr);
          check("hold_valid", 64'(wr_valid), 64'd0);
          check("page_done", 64'(page_done), 64'(in_page == 31));
          in_page++;
          req_done++;
          hold_chk = 0;
        end else begin
          check("page_done_idle", 64'(page_done), 64'd0);
        end
        if (pa_valid && pa_ready) begin
          in_page = 0;
          pa_acc++;
        end
        if (wr_valid && wr_ready) begin
          if (beat_cnt == 0) begin
            if (exp_addr.size() == 0) fail_now("unexpected_request");
            else begin
              cur_addr = exp_addr.pop_front();
              check("req_addr", wr_addr, cur_addr);
            end
          end
          if (exp_data.size() == 0) fail_now("unexpected_beat");
          else check("beat_data", wr_data, exp_data.pop_front());
          check("rd_en_beat", 64'(fifo_rd_en), 64'd1);
          beat_cnt++;
          if (beat_cnt == 16) begin
            beat_cnt = 0;
            hold_chk = 1;
          end
        end else if (wr_ready && !wr_valid) begin
          check("stray_pop", 64'(fifo_rd_en), 64'd0);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic send_pa(input logic [63:0] addr, input int budget);
    int n = 0;
    pa_data  = addr;
    pa_valid = 1'b1;
    while (!pa_ready && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) fail_now("pa_ready_timeout");
    tick();
    pa_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (n < budget && !(exp_addr.size() == 0 && beat_cnt == 0 && !hold_chk)) begin
      tick();
      n++;
    end
    if (n >= budget) fail_now(name);
    repeat (3) tick();
  endtask

  function automatic logic [31:0] exp_req_count();
`ifdef PCIE_WR_SEQ_REQ_COUNT_EN
    return 32'(req_done);
`else
    return 32'd0;
`endif
  endfunction

  // ---------------- directed tests ----------------
  initial begin
    int n;
    reset    = 1'b1;
    enable   = 1'b0;
    pa_valid = 1'b0;
    pa_data  = '0;
    repeat (3) tick();

    // Reset values
    check("rst_wr_valid",   64'(wr_valid),   64'd0);
    check("rst_pa_ready",   64'(pa_ready),   64'd0);
    check("rst_fifo_rd_en", 64'(fifo_rd_en), 64'd0);
    check("rst_page_done",  64'(page_done),  64'd0);
    check("rst_req_count",  64'(req_count),  64'd0);
    check("rst_wr_addr",    wr_addr,         64'd0);
    check("rst_state",      64'(dut.r_state), 64'(IDLE));
    reset = 1'b0;
    tick();

    // Single page, low address bits must be ignored
    enable = 1'b1;
    push_words(512);
    push_addrs(64'h0000_0001_2345_6000, 0, 31);
    send_pa(64'h0000_0001_2345_6ABC, 50);
    wait_done("page1_timeout", 4000);
    check("page1_done_pulses", 64'(pd_count), 64'd1);
    check("page1_reqs", 64'(req_done), 64'd32);
    check("page1_req_count", 64'(req_count), 64'(exp_req_count()));

    // Partial FIFO: 15 words never start a request, 16 does one cycle later
    push_words(15);
    push_addrs(64'h0000_0000_0004_2000, 0, 0);
    send_pa(64'h0000_0000_0004_2000, 50);
    repeat (6) begin
      tick();
      check("partial_no_valid", 64'(wr_valid), 64'd0);
    end
    push_words(1);
    tick();
    check("partial_valid_rise", 64'(wr_valid), 64'd1);

    // Enable drop at beat 5 of request 3 of this page
    push_words(496);
    push_addrs(64'h0000_0000_0004_2000, 1, 31);
    n = 0;
    while (!(req_done == 32 + 3 && beat_cnt == 5) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) fail_now("endrop_beat5_timeout");
    enable = 1'b0;
    n = 0;
    while (req_done != 32 + 4 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) fail_now("endrop_finish_timeout");
    repeat (20) begin
      tick();
      check("endrop_parked", 64'(wr_valid), 64'd0);
    end
    enable = 1'b1;
    wait_done("page2_timeout", 4000);
    check("page2_done_pulses", 64'(pd_count), 64'd2);
    check("page2_req_count", 64'(req_count), 64'(exp_req_count()));

    // Page rollover: two queued pages
    n = pa_acc;
    push_words(1024);
    push_addrs(64'h0000_0000_0000_1000, 0, 31);
    push_addrs(64'h0000_0000_8000_0000, 0, 31);
    send_pa(64'h0000_0000_0000_1000, 50);
    send_pa(64'h0000_0000_8000_0000, 3000);
    wait_done("rollover_timeout", 4000);
    check("rollover_pa_accepts", 64'(pa_acc - n), 64'd2);
    check("rollover_done_pulses", 64'(pd_count), 64'd4);

    // Reset in the middle of a request
    push_words(32);
    push_addrs(64'h0000_0000_0000_5000, 0, 1);
    send_pa(64'h0000_0000_0000_5000, 50);
    n = 0;
    while (beat_cnt != 8 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) fail_now("midreq_beat8_timeout");
    reset  = 1'b1;
    wr_ptr = 0;
    exp_data.delete();
    exp_addr.delete();
    tick();
    check("midrst_wr_valid", 64'(wr_valid), 64'd0);
    check("midrst_state", 64'(dut.r_state), 64'(IDLE));
    check("midrst_req_count", 64'(req_count), 64'd0);
    tick();
    reset = 1'b0;
    push_words(32);
    repeat (20) begin
      tick();
      check("postrst_needs_pa", 64'(wr_valid), 64'd0);
    end
    push_addrs(64'h0000_0000_0000_9000, 0, 1);
    send_pa(64'h0000_0000_0000_9000, 50);
    wait_done("postrst_timeout", 500);
    check("postrst_reqs", 64'(req_done), 64'd2);
    check("postrst_req_count", 64'(req_count), 64'(exp_req_count()));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pcie_wr_seq
`default_nettype wire
